// File: rtl/kg_arb2.sv
// Two-channel round-robin arbiter and start/done sequencer for one shared
// Kalman-gain engine, with a watchdog that turns a hung job into an error pulse.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 12
`endif

module kg_arb2 #(
  parameter int N       = `FXP_N,
  parameter int FRAC    = `FXP_FRAC,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic [12*N-1:0] ops0,
  input  logic [12*N-1:0] ops1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            kvalid0,
  output logic            kvalid1,
  output logic            err0,
  output logic            err1,
  output logic [4*N-1:0]  k_out,
  output logic            busy,
  output logic            eng_start,
  output logic [12*N-1:0] eng_ops,
  input  logic            eng_done,
  input  logic [4*N-1:0]  eng_k
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [12*N-1:0] ops_q, ops_d;
  logic [4*N-1:0]  k_q, k_d;
  logic            win;

  // Fixed-point format is carried for the engine's benefit only.
  logic [31:0]     unused_frac;
  assign unused_frac = 32'(FRAC);

  // On a tie the channel that did not win last time gets the grant.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_LAUNCH;
          sel_d   = win;
          last_d  = win;
          ops_d   = win ? ops1 : ops0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (eng_done) begin
          k_d     = eng_k;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ops_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    eng_start = (state_q == S_LAUNCH);
    gnt0      = (state_q == S_LAUNCH) && !sel_q;
    gnt1      = (state_q == S_LAUNCH) &&  sel_q;
    kvalid0   = (state_q == S_RESP) && !err_q && !sel_q;
    kvalid1   = (state_q == S_RESP) && !err_q &&  sel_q;
    err0      = (state_q == S_RESP) &&  err_q && !sel_q;
    err1      = (state_q == S_RESP) &&  err_q &&  sel_q;
    eng_ops   = ops_q;
    k_out     = k_q;
  end

endmodule
